// File: rtl/sensor_temp_acquire.sv
// Temperature sensor acquisition: SPI mode-0 frame capture, saturation to 0..63 degC
// and a 4-sample sliding average presented as a registered value with a one-cycle strobe.
module sensor_temp_acquire #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       start_req,
    input  logic       miso,
    output logic       sclk,
    output logic       cs_n,
    output logic [5:0] temp_value,
    output logic       temp_valid,
    output logic       sensor_fault,
    output logic       busy
);

    localparam int PER_W = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        PROCESS
    } state_t;

    state_t             state;
    logic [PER_W-1:0]   period_cnt;
    logic               trigger;
    logic [1:0]         miso_sync;
    logic [7:0]         div_cnt;
    logic               div_last;
    logic [4:0]         edge_cnt;
    logic [15:0]        shift_reg;
    logic               primed;
    logic [5:0]         win0;
    logic [5:0]         win1;
    logic [5:0]         win2;
    logic [5:0]         sample_sat;
    logic               frame_invalid;
    logic [7:0]         sum;

    assign trigger       = enable && (period_cnt == PER_W'(SAMPLE_PERIOD - 1));
    assign div_last      = (div_cnt == 8'(CLK_DIV - 1));
    assign frame_invalid = (shift_reg == 16'hFFFF);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
        end else if (enable) begin
            if (period_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], miso};
        end
    end

    // Signed integer degrees from the frame's upper byte, clamped into 0..63.
    always_comb begin
        sample_sat = shift_reg[13:8];
        if (shift_reg[15]) begin
            sample_sat = 6'd0;
        end else if (shift_reg[14]) begin
            sample_sat = 6'd63;
        end
    end

    // win0..win2 hold the three previous samples; the new sample is the fourth entry.
    assign sum = {2'b00, sample_sat} + {2'b00, win0} + {2'b00, win1} + {2'b00, win2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            sclk         <= 1'b0;
            cs_n         <= 1'b1;
            div_cnt      <= 8'd0;
            edge_cnt     <= 5'd0;
            shift_reg    <= 16'd0;
            primed       <= 1'b0;
            win0         <= 6'd0;
            win1         <= 6'd0;
            win2         <= 6'd0;
            temp_value   <= 6'd0;
            temp_valid   <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger || start_req) begin
                        state     <= CS_SETUP;
                        cs_n      <= 1'b0;
                        div_cnt   <= 8'd0;
                        shift_reg <= 16'd0;
                    end
                end
                CS_SETUP: begin
                    if (div_last) begin
                        state    <= SHIFT;
                        div_cnt  <= 8'd0;
                        edge_cnt <= 5'd0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    // Capture in the first cycle sclk is high, giving the synchroniser time to settle.
                    if (sclk && (div_cnt == 8'd0)) begin
                        shift_reg <= {shift_reg[14:0], miso_sync[1]};
                    end
                    if (div_last) begin
                        div_cnt <= 8'd0;
                        sclk    <= ~sclk;
                        if (edge_cnt == 5'd31) begin
                            sclk  <= 1'b0;
                            cs_n  <= 1'b1;
                            state <= PROCESS;
                        end else begin
                            edge_cnt <= edge_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                PROCESS: begin
                    state <= IDLE;
                    if (frame_invalid) begin
                        sensor_fault <= 1'b1;
                    end else begin
                        sensor_fault <= 1'b0;
                        temp_valid   <= 1'b1;
                        if (!primed) begin
                            primed     <= 1'b1;
                            win0       <= sample_sat;
                            win1       <= sample_sat;
                            win2       <= sample_sat;
                            temp_value <= sample_sat;
                        end else begin
                            win0       <= sample_sat;
                            win1       <= win0;
                            win2       <= win1;
                            temp_value <= sum[7:2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_temp_acquire.sv
// Self-checking bench for sensor_temp_acquire: directed frames plus random frames
// checked against a queue-based averaging model and a behavioural SPI sensor.
module tb_sensor_temp_acquire;

    localparam int CLK_DIV       = 2;
    localparam int SAMPLE_PERIOD = 1000;
    localparam int LATENCY       = CLK_DIV * 33 + 1;
    localparam int CS_LOW        = CLK_DIV * 33;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       start_req;
    logic       miso;
    logic       sclk;
    logic       cs_n;
    logic [5:0] temp_value;
    logic       temp_valid;
    logic       sensor_fault;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] frame = 16'h0000;
    int          bit_idx = 15;
    logic        sclk_prev = 1'b0;
    int          cs_fall_count = 0;
    int          valid_count = 0;

    int          win_q[$];
    logic [5:0]  model_value;
    logic        model_fault;

    sensor_temp_acquire #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .start_req   (start_req),
        .miso        (miso),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .temp_value  (temp_value),
        .temp_valid  (temp_valid),
        .sensor_fault(sensor_fault),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Sensor: presents the MSB when selected and advances one bit per falling sclk.
    always @(cs_n or sclk) begin
        if (cs_n) begin
            bit_idx = 15;
        end else if (sclk_prev && !sclk && bit_idx > 0) begin
            bit_idx = bit_idx - 1;
        end
        sclk_prev = sclk;
    end

    assign miso = frame[bit_idx[3:0]];

    always @(negedge cs_n) cs_fall_count++;

    always @(posedge clk) if (temp_valid === 1'b1) valid_count++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        win_q.delete();
        model_value = 6'd0;
        model_fault = 1'b0;
    endtask

    task automatic modelPush(input logic [15:0] f, output bit valid);
        int t;
        int s;
        int total;
        if (f == 16'hFFFF) begin
            valid       = 1'b0;
            model_fault = 1'b1;
            return;
        end
        valid       = 1'b1;
        model_fault = 1'b0;
        t = int'($signed(f[15:8]));
        s = (t < 0) ? 0 : ((t > 63) ? 63 : t);
        if (win_q.size() == 0) begin
            repeat (4) win_q.push_back(s);
        end else begin
            void'(win_q.pop_front());
            win_q.push_back(s);
        end
        total = 0;
        foreach (win_q[i]) total += win_q[i];
        model_value = 6'(total / 4);
    endtask

    // Waits for cs_n to fall, then watches 120 cycles measured from that cycle.
    task automatic waitResult(input bit drop_enable, output int wait_n, output int low,
                              output int valid_at, output int vcount, output logic [5:0] val);
        wait_n   = 0;
        low      = 0;
        valid_at = -1;
        vcount   = 0;
        while (cs_n !== 1'b0 && wait_n < 1500) begin
            @(negedge clk);
            wait_n++;
        end
        val = temp_value;
        for (int t = 0; t < 120; t++) begin
            if (drop_enable && t == 5) enable = 1'b0;
            if (cs_n === 1'b0) low++;
            if (temp_valid === 1'b1) begin
                vcount++;
                if (valid_at < 0) begin
                    valid_at = t;
                    val      = temp_value;
                end
            end
            @(negedge clk);
        end
        if (valid_at < 0) val = temp_value;
    endtask

    task automatic applyStimulus(input logic [15:0] f, output int low, output int valid_at,
                                 output int vcount, output logic [5:0] val);
        int wait_n;
        frame = f;
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        waitResult(1'b0, wait_n, low, valid_at, vcount, val);
    endtask

    task automatic runFrame(input string tag, input logic [15:0] f);
        int         low;
        int         valid_at;
        int         vcount;
        logic [5:0] val;
        bit         valid;
        applyStimulus(f, low, valid_at, vcount, val);
        modelPush(f, valid);
        checkOutput({tag, "_cs_low"}, low, CS_LOW);
        if (valid) begin
            checkOutput({tag, "_latency"}, valid_at, LATENCY);
            checkOutput({tag, "_pulses"}, vcount, 1);
            checkOutput({tag, "_value"}, val, model_value);
        end else begin
            checkOutput({tag, "_pulses"}, vcount, 0);
            checkOutput({tag, "_held"}, val, model_value);
        end
        checkOutput({tag, "_fault"}, sensor_fault, model_fault);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_sclk"}, sclk, 0);
        checkOutput({tag, "_cs_n"}, cs_n, 1);
        checkOutput({tag, "_value"}, temp_value, 0);
        checkOutput({tag, "_valid"}, temp_valid, 0);
        checkOutput({tag, "_fault"}, sensor_fault, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int         falls_before;
        int         valids_before;
        int         edges;
        int         cyc;
        logic       last_sclk;
        int         wait_n;
        int         low;
        int         valid_at;
        int         vcount;
        logic [5:0] val;
        bit         valid;
        logic [15:0] rf;

        rst       = 1'b0;
        enable    = 1'b0;
        start_req = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkIdleOutputs("in_reset");

        rst = 1'b1;
        repeat (900) @(negedge clk);
        checkIdleOutputs("idle_900");
        checkOutput("idle_no_cs", cs_fall_count, 0);

        runFrame("f1980", 16'h1980);
        runFrame("f1D00_a", 16'h1D00);
        runFrame("f1D00_b", 16'h1D00);
        runFrame("f1D00_c", 16'h1D00);
        runFrame("f1D00_d", 16'h1D00);

        // A request while busy must be dropped.
        falls_before = cs_fall_count;
        frame = 16'h1D00;
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (10) @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (150) @(negedge clk);
        modelPush(16'h1D00, valid);
        checkOutput("busy_req_dropped", cs_fall_count - falls_before, 1);
        checkOutput("busy_req_value", temp_value, model_value);

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        modelReset();
        runFrame("fF600", 16'hF600);
        runFrame("f5000", 16'h5000);
        runFrame("fFFFF", 16'hFFFF);
        runFrame("f1400", 16'h1400);

        for (int i = 0; i < 10; i++) begin
            rf = 16'($urandom);
            if ($urandom_range(0, 3) == 0) rf = 16'hFFFF;
            runFrame($sformatf("rand%0d", i), rf);
        end

        // Reset in the middle of the shift phase, with a dropped request while busy.
        frame = 16'($urandom);
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        edges     = 0;
        cyc       = 0;
        last_sclk = sclk;
        while (edges < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) start_req = 1'b1;
            if (cyc == 6) start_req = 1'b0;
            if (sclk !== last_sclk) edges++;
            last_sclk = sclk;
        end
        checkOutput("midshift_edges", edges, 8);
        rst = 1'b0;
        #1;
        checkOutput("midshift_cs_n", cs_n, 1);
        checkOutput("midshift_sclk", sclk, 0);
        checkOutput("midshift_busy", busy, 0);
        checkOutput("midshift_valid", temp_valid, 0);
        falls_before  = cs_fall_count;
        valids_before = valid_count;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        modelReset();
        repeat (300) @(negedge clk);
        checkOutput("after_reset_no_cs", cs_fall_count - falls_before, 0);
        checkOutput("after_reset_no_valid", valid_count - valids_before, 0);
        checkOutput("after_reset_value", temp_value, 0);

        // Periodic acquisition; enable dropped mid-transaction must not abort it.
        frame  = 16'h2A00;
        enable = 1'b1;
        waitResult(1'b1, wait_n, low, valid_at, vcount, val);
        modelPush(16'h2A00, valid);
        checkOutput("period_wait", wait_n, SAMPLE_PERIOD);
        checkOutput("period_cs_low", low, CS_LOW);
        checkOutput("period_latency", valid_at, LATENCY);
        checkOutput("period_pulses", vcount, 1);
        checkOutput("period_value", val, model_value);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sensor_temp_acquire.md
SENSOR_TEMP_ACQUIRE -- requirements
Module: sensor_temp_acquire

Interface
REQ-001 Parameter CLK_DIV, 4, number of clk cycles per sclk half-period (legal range 2..255).
REQ-002 Parameter SAMPLE_PERIOD, 50000000, number of clk cycles between automatic acquisitions (legal range 64 or more).
REQ-003 Port clk  input  1  system clock, all logic on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port enable  input  1  allows periodic acquisition while high.
REQ-006 Port start_req  input  1  single-cycle request for an immediate acquisition.
REQ-007 Port miso  input  1  serial data from the temperature sensor (synchronised internally with 2 flops).
REQ-008 Port sclk  output  1  serial clock to the sensor, SPI mode 0, idles low.
REQ-009 Port cs_n  output  1  sensor chip select, active-low.
REQ-010 Port temp_value  output  6  averaged temperature in whole °C, range 0..63; feeds the comparator stage tpValor.
REQ-011 Port temp_valid  output  1  one-cycle strobe marking a new temp_value; drives the comparator stage startComp.
REQ-012 Port sensor_fault  output  1  last frame was invalid.
REQ-013 Port busy  output  1  transaction in progress (any state other than IDLE).

Function
REQ-014 The FSM SHALL have the states IDLE, CS_SETUP, SHIFT, PROCESS.
REQ-015 The period counter SHALL count clk cycles while enable=1 and SHALL hold its value while enable=0. When the count reaches SAMPLE_PERIOD-1, it SHALL wrap to 0 and raise a trigger.
REQ-016 From IDLE, a trigger or start_req=1 SHALL cause the next state to be CS_SETUP with cs_n=0. A trigger or start_req arriving when the FSM is not in IDLE SHALL be dropped, with no queuing.
REQ-017 CS_SETUP SHALL last CLK_DIV cycles with sclk=0, then move to SHIFT.
REQ-018 In SHIFT, sclk SHALL toggle every CLK_DIV cycles for 16 rising and 16 falling edges. On the cycle sclk goes 0 to 1, the synchronised miso SHALL be shifted in MSB first.
REQ-019 After the 16th falling edge, cs_n SHALL go to 1 and the FSM SHALL move to PROCESS. PROCESS SHALL last exactly 1 cycle, then the FSM SHALL return to IDLE.
REQ-020 Frame decoding: frame[15:8] SHALL be taken as a signed 8-bit integer °C, and frame[7:0] (the fraction) SHALL be discarded.
REQ-021 Saturation: a negative value SHALL be clamped to 0, and a value above 63 SHALL be clamped to 63.
REQ-022 A frame equal to 16'hFFFF SHALL be treated as invalid. In PROCESS for an invalid frame: sensor_fault SHALL be set to 1, there SHALL be no temp_valid, and temp_value and the window SHALL be unchanged.
REQ-023 In PROCESS for a valid frame: sensor_fault SHALL be cleared to 0.
REQ-024 Averaging SHALL use a 4-entry sliding window of saturated samples. The sum SHALL be 8 bits wide (no overflow) and temp_value SHALL be sum>>2, truncated.
REQ-025 The first valid sample after reset SHALL fill all 4 window entries, so temp_value equals that sample.
REQ-026 temp_value SHALL be registered and update on the clk edge that ends PROCESS. temp_valid SHALL be high for exactly that one following cycle.
REQ-027 From cs_n falling to temp_valid, latency SHALL be CLK_DIV*33 + 1 cycles, fixed.
REQ-028 A change of enable to 0 mid-transaction SHALL NOT abort it.

Reset
REQ-029 While rst=0, the outputs SHALL be: sclk=0, cs_n=1, temp_value=0, temp_valid=0, sensor_fault=0, busy=0. The FSM SHALL be in IDLE, the period counter at 0, the window marked unprimed, and the shift register at 0.
REQ-030 Reset assertion mid-SHIFT SHALL immediately force cs_n=1 and sclk=0, and SHALL discard the partial frame.
REQ-031 After rst is released, the first acquisition SHALL occur no earlier than SAMPLE_PERIOD cycles later, unless start_req is asserted.

Verification (CLK_DIV=2, SAMPLE_PERIOD=1000)
REQ-032 Release reset and hold 900 cycles with enable=0 -> all outputs at their reset values and cs_n never asserted.
REQ-033 start_req pulse with sensor model frame 0x1980 (25.5 °C) -> cs_n low for 66 cycles, then temp_value=25 with a single-cycle temp_valid 67 cycles after cs_n fell.
REQ-034 Then frames 0x1D00 x3 (29 °C) -> temp_value sequence 26, 27, 28. A fourth 0x1D00 -> 29.
REQ-035 After a new reset, frame 0xF600 (-10 °C) -> 0. Then 0x5000 (80 °C) -> window {0,0,0,63} gives 15.
REQ-036 Frame 0xFFFF -> sensor_fault=1, no temp_valid, temp_value held. The next frame 0x1400 -> sensor_fault=0 and temp_valid pulses.
REQ-037 rst low during the 8th sclk edge, plus start_req during busy -> cs_n=1 and sclk=0 within the reset cycle, no temp_valid. The start_req issued during busy produces no extra transaction.
